// File: rtl/register_file_pkg.sv
// Shared rename/commit constants used by the ROB, the decoder and the register file.
// The widths below are the defaults that register_file picks up for its parameters.
package register_file_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_ID_W  = 5;
    localparam int REG_COUNT = 32;
    localparam int REG_ID_W  = 5;

    localparam logic [ROB_ID_W-1:0] NO_DEP = 5'd0;
    localparam logic [REG_ID_W-1:0] REG_X0 = 5'd0;

    // x0 is hard-wired, so only indices 1..31 carry architectural state.
    function automatic logic is_arch_reg(input logic [REG_ID_W-1:0] idx);
        return (idx != REG_X0);
    endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file with rename tags. It has two combinational read
// ports, a commit write port with read bypass, and a launch rename port.
module register_file #(
    parameter int XLEN     = register_file_pkg::XLEN,
    parameter int ROB_ID_W = register_file_pkg::ROB_ID_W
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                _clear,
    input  logic                _rf_launch_ready,
    input  logic [ROB_ID_W-1:0] _rf_launch_rob_id,
    input  logic [4:0]          _rf_launch_register_id,
    input  logic                _rf_commit_ready,
    input  logic [ROB_ID_W-1:0] _rf_commit_rob_id,
    input  logic [4:0]          _rf_commit_register_id,
    input  logic [XLEN-1:0]     _rf_commit_value,
    input  logic [4:0]          _ask_rd_1,
    input  logic [4:0]          _ask_rd_2,
    output logic [ROB_ID_W-1:0] _dep_rd_1,
    output logic [ROB_ID_W-1:0] _dep_rd_2,
    output logic [XLEN-1:0]     _dep_value_1,
    output logic [XLEN-1:0]     _dep_value_2
);

    import register_file_pkg::*;

    logic [XLEN-1:0]     regs_r     [REG_COUNT];
    logic [ROB_ID_W-1:0] dep_r      [REG_COUNT];
    logic [XLEN-1:0]     regs_nxt_s [REG_COUNT];
    logic [ROB_ID_W-1:0] dep_nxt_s  [REG_COUNT];

    logic commit_en_s;
    logic launch_en_s;

    // Qualify the write ports: x0 is never written and a flush cancels renames.
    always_comb begin
        commit_en_s = _rf_commit_ready && is_arch_reg(_rf_commit_register_id);
        launch_en_s = _rf_launch_ready && is_arch_reg(_rf_launch_register_id) && !_clear;
    end

    // Next-state per entry. Priority for the tag is flush, then launch, then the commit clear.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_nxt_s[i] = regs_r[i];
            dep_nxt_s[i]  = dep_r[i];
            if (i == 0) begin
                regs_nxt_s[i] = {XLEN{1'b0}};
                dep_nxt_s[i]  = {ROB_ID_W{1'b0}};
            end else begin
                if (commit_en_s && (_rf_commit_register_id == REG_ID_W'(i))) begin
                    regs_nxt_s[i] = _rf_commit_value;
                end else begin
                    regs_nxt_s[i] = regs_r[i];
                end

                if (_clear) begin
                    dep_nxt_s[i] = {ROB_ID_W{1'b0}};
                end else if (launch_en_s && (_rf_launch_register_id == REG_ID_W'(i))) begin
                    dep_nxt_s[i] = _rf_launch_rob_id;
                end else if (commit_en_s && (_rf_commit_register_id == REG_ID_W'(i))
                             && (dep_r[i] == _rf_commit_rob_id)) begin
                    dep_nxt_s[i] = {ROB_ID_W{1'b0}};
                end else begin
                    dep_nxt_s[i] = dep_r[i];
                end
            end
        end
    end

    // State registers. rdy_in low freezes everything, and reset clears it at any time.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
                dep_r[i]  <= {ROB_ID_W{1'b0}};
            end
        end else if (rdy_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= regs_nxt_s[i];
                dep_r[i]  <= dep_nxt_s[i];
            end
        end
    end

    // Read port 1: a retiring producer forwards its value in the same cycle.
    always_comb begin
        _dep_rd_1    = dep_r[_ask_rd_1];
        _dep_value_1 = regs_r[_ask_rd_1];
        if (!is_arch_reg(_ask_rd_1)) begin
            _dep_rd_1    = {ROB_ID_W{1'b0}};
            _dep_value_1 = {XLEN{1'b0}};
        end else if (_rf_commit_ready && (_ask_rd_1 == _rf_commit_register_id)
                     && (dep_r[_ask_rd_1] == _rf_commit_rob_id)) begin
            _dep_rd_1    = {ROB_ID_W{1'b0}};
            _dep_value_1 = _rf_commit_value;
        end else begin
            _dep_rd_1    = dep_r[_ask_rd_1];
            _dep_value_1 = regs_r[_ask_rd_1];
        end
    end

    // Read port 2: the same bypass as port 1, kept as an independent copy.
    always_comb begin
        _dep_rd_2    = dep_r[_ask_rd_2];
        _dep_value_2 = regs_r[_ask_rd_2];
        if (!is_arch_reg(_ask_rd_2)) begin
            _dep_rd_2    = {ROB_ID_W{1'b0}};
            _dep_value_2 = {XLEN{1'b0}};
        end else if (_rf_commit_ready && (_ask_rd_2 == _rf_commit_register_id)
                     && (dep_r[_ask_rd_2] == _rf_commit_rob_id)) begin
            _dep_rd_2    = {ROB_ID_W{1'b0}};
            _dep_value_2 = _rf_commit_value;
        end else begin
            _dep_rd_2    = dep_r[_ask_rd_2];
            _dep_value_2 = regs_r[_ask_rd_2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scenario bench for register_file: expected read-port results are queued when
// stimulus is applied and compared once the outputs settle.
`timescale 1ns/1ps
module tb_register_file;

    typedef struct packed {
        logic [4:0]  d1;
        logic [31:0] v1;
        logic [4:0]  d2;
        logic [31:0] v2;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        l_en;
    logic [4:0]  l_tag;
    logic [4:0]  l_rd;
    logic        c_en;
    logic [4:0]  c_tag;
    logic [4:0]  c_rd;
    logic [31:0] c_val;
    logic [4:0]  ask1;
    logic [4:0]  ask2;
    logic [4:0]  dep1;
    logic [4:0]  dep2;
    logic [31:0] val1;
    logic [31:0] val2;

    rd_t exp_q[$];
    rd_t e;
    rd_t obs;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk_in                 (clk),
        .rst_in                 (rst),
        .rdy_in                 (rdy),
        ._clear                 (clear),
        ._rf_launch_ready       (l_en),
        ._rf_launch_rob_id      (l_tag),
        ._rf_launch_register_id (l_rd),
        ._rf_commit_ready       (c_en),
        ._rf_commit_rob_id      (c_tag),
        ._rf_commit_register_id (c_rd),
        ._rf_commit_value       (c_val),
        ._ask_rd_1              (ask1),
        ._ask_rd_2              (ask2),
        ._dep_rd_1              (dep1),
        ._dep_rd_2              (dep2),
        ._dep_value_1           (val1),
        ._dep_value_2           (val2)
    );

    task automatic drive(input logic le, input logic [4:0] lrd, input logic [4:0] ltag,
                         input logic ce, input logic [4:0] crd, input logic [4:0] ctag,
                         input logic [31:0] cval, input logic clr);
        l_en = le;  l_rd = lrd;  l_tag = ltag;
        c_en = ce;  c_rd = crd;  c_tag = ctag;  c_val = cval;
        clear = clr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; idle();
        ask1 = 5'd5; ask2 = 5'd31;
        exp_q.push_back('{5'd0, 32'd0, 5'd0, 32'd0});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_state: got %h want %h", obs, e); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_launch_commit();
        @(negedge clk);
        drive(1'b1, 5'd5, 5'd3, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        ask1 = 5'd5; ask2 = 5'd0;
        exp_q.push_back('{5'd0, 32'd0, 5'd0, 32'd0});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL pre_rename_read: got %h want %h", obs, e); end

        @(negedge clk); idle();
        exp_q.push_back('{5'd3, 32'd0, 5'd0, 32'd0});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL launch_visible: got %h want %h", obs, e); end

        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd3, 32'h0000_1234, 1'b0);
        exp_q.push_back('{5'd0, 32'h0000_1234, 5'd0, 32'd0});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL commit_bypass: got %h want %h", obs, e); end

        @(negedge clk); idle();
        exp_q.push_back('{5'd0, 32'h0000_1234, 5'd0, 32'd0});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL commit_retired: got %h want %h", obs, e); end
    endtask

    task automatic test_rename_bypass();
        @(negedge clk); drive(1'b1, 5'd5, 5'd3, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk); drive(1'b1, 5'd5, 5'd7, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk); drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd3, 32'h0000_00AA, 1'b0);
        ask1 = 5'd5; ask2 = 5'd5;
        exp_q.push_back('{5'd7, 32'h0000_1234, 5'd7, 32'h0000_1234});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL stale_commit_no_bypass: got %h want %h", obs, e); end

        @(negedge clk); idle();
        exp_q.push_back('{5'd7, 32'h0000_00AA, 5'd7, 32'h0000_00AA});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL stale_commit_keeps_tag: got %h want %h", obs, e); end

        @(negedge clk); drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd7, 32'h0000_00BB, 1'b0);
        exp_q.push_back('{5'd0, 32'h0000_00BB, 5'd0, 32'h0000_00BB});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL bypass_both_ports: got %h want %h", obs, e); end

        @(negedge clk); idle();
        exp_q.push_back('{5'd0, 32'h0000_00BB, 5'd0, 32'h0000_00BB});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL final_commit: got %h want %h", obs, e); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk); drive(1'b1, 5'd8, 5'd4, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        ask1 = 5'd8; ask2 = 5'd5;
        @(negedge clk); drive(1'b1, 5'd8, 5'd9, 1'b1, 5'd8, 5'd4, 32'h0000_0055, 1'b0);
        exp_q.push_back('{5'd0, 32'h0000_0055, 5'd0, 32'h0000_00BB});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL same_cycle_bypass: got %h want %h", obs, e); end

        @(negedge clk); idle();
        exp_q.push_back('{5'd9, 32'h0000_0055, 5'd0, 32'h0000_00BB});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL launch_wins: got %h want %h", obs, e); end
    endtask

    task automatic test_clear();
        logic [31:0] v;
        for (int r = 1; r < 32; r++) begin
            @(negedge clk); drive(1'b1, 5'(r), 5'(r), 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        end
        @(negedge clk); idle();
        ask1 = 5'd17; ask2 = 5'd31;
        exp_q.push_back('{5'd17, 32'd0, 5'd31, 32'd0});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL renamed_all: got %h want %h", obs, e); end

        @(negedge clk); drive(1'b1, 5'd9, 5'd12, 1'b1, 5'd2, 5'd5, 32'h0000_0077, 1'b1);
        ask1 = 5'd2; ask2 = 5'd9;
        exp_q.push_back('{5'd2, 32'd0, 5'd9, 32'd0});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL clear_cycle_reads: got %h want %h", obs, e); end

        @(negedge clk); idle();
        ask2 = 5'd0;
        for (int r = 1; r < 32; r++) begin
            ask1 = 5'(r);
            v = (r == 2) ? 32'h0000_0077 : (r == 5) ? 32'h0000_00BB : (r == 8) ? 32'h0000_0055 : 32'd0;
            exp_q.push_back('{5'd0, v, 5'd0, 32'd0});
            #2;
            e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
            if (obs !== e) begin errors++; $display("FAIL after_clear_x%0d: got %h want %h", r, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_x0();
        @(negedge clk); drive(1'b1, 5'd0, 5'd6, 1'b1, 5'd0, 5'd6, 32'hFFFF_FFFF, 1'b0);
        ask1 = 5'd0; ask2 = 5'd0;
        exp_q.push_back('{5'd0, 32'd0, 5'd0, 32'd0});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL x0_no_bypass: got %h want %h", obs, e); end

        @(negedge clk); idle();
        exp_q.push_back('{5'd0, 32'd0, 5'd0, 32'd0});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL x0_hardwired: got %h want %h", obs, e); end
    endtask

    task automatic test_rdy_low();
        @(negedge clk); rdy = 1'b0;
        drive(1'b1, 5'd10, 5'd11, 1'b1, 5'd5, 5'd0, 32'h0000_DEAD, 1'b0);
        ask1 = 5'd10; ask2 = 5'd2;
        exp_q.push_back('{5'd0, 32'd0, 5'd0, 32'h0000_0077});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL rdy_low_reads: got %h want %h", obs, e); end

        @(negedge clk); rdy = 1'b1; idle();
        ask1 = 5'd10; ask2 = 5'd5;
        exp_q.push_back('{5'd0, 32'd0, 5'd0, 32'h0000_00BB});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL rdy_low_hold: got %h want %h", obs, e); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); drive(1'b1, 5'd3, 5'd2, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk); idle();
        ask1 = 5'd3; ask2 = 5'd2;
        exp_q.push_back('{5'd2, 32'd0, 5'd0, 32'h0000_0077});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL pre_reset_state: got %h want %h", obs, e); end

        #1 rst = 1'b1;
        exp_q.push_back('{5'd0, 32'd0, 5'd0, 32'd0});
        #1;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL async_reset_immediate: got %h want %h", obs, e); end

        @(negedge clk); rst = 1'b0;
        drive(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        ask1 = 5'd3; ask2 = 5'd8;
        @(negedge clk); idle();
        exp_q.push_back('{5'd4, 32'd0, 5'd0, 32'd0});
        #2;
        e = exp_q.pop_front(); obs = '{dep1, val1, dep2, val2}; checks++;
        if (obs !== e) begin errors++; $display("FAIL fresh_after_reset: got %h want %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_launch_commit();
        test_rename_bypass();
        test_same_cycle();
        test_clear();
        test_x0();
        test_rdy_low();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter XLEN, 32, data width of each architectural register.
REQ-002 Parameter ROB_ID_W, 5, width of a ROB tag; tag 0 means "no dependency", tags 1..31 are valid ROB entries.
REQ-003 clk_in  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_in  input  1  asynchronous, active-high reset.
REQ-005 rdy_in  input  1  global ready; low freezes all state.
REQ-006 _clear  input  1  pipeline flush (branch mispredict).
REQ-007 _rf_launch_ready  input  1  rename request for a newly issued instruction with rd.
REQ-008 _rf_launch_rob_id  input  5  ROB tag of the issuing instruction.
REQ-009 _rf_launch_register_id  input  5  destination register of the issuing instruction.
REQ-010 _rf_commit_ready  input  1  retire request carrying a result.
REQ-011 _rf_commit_rob_id  input  5  ROB tag of the retiring instruction.
REQ-012 _rf_commit_register_id  input  5  destination register of the retiring instruction.
REQ-013 _rf_commit_value  input  32  result to write.
REQ-014 _ask_rd_1 / _ask_rd_2  input  5 each  source register indices to look up.
REQ-015 _dep_rd_1 / _dep_rd_2  output  5 each  pending ROB tag for each source; 0 = none.
REQ-016 _dep_value_1 / _dep_value_2  output  32 each  architectural value for each source.

Function
REQ-017 State: 32 x 32-bit value array regs[] and 32 x 5-bit tag array dep[]; x0 is hard-wired: reads return value 0 and tag 0, and writes to x0 are discarded.
REQ-018 Read ports are combinational, with zero latency.
REQ-019 Commit bypass: if _rf_commit_ready, _ask_rd_N == _rf_commit_register_id != 0, and dep[_ask_rd_N] == _rf_commit_rob_id, then _dep_rd_N = 0 and _dep_value_N = _rf_commit_value.
REQ-020 Reads never reflect a launch in the same cycle; the issuing instruction's own sources see the pre-rename tag.
REQ-021 Commit (rdy_in high, _rf_commit_ready, rd != 0): regs[rd] <= _rf_commit_value unconditionally; dep[rd] <= 0 only if dep[rd] == _rf_commit_rob_id.
REQ-022 Launch (rdy_in high, _rf_launch_ready, rd != 0, _clear low): dep[rd] <= _rf_launch_rob_id.
REQ-023 Launch and commit to the same rd in one cycle: the value is written, and dep[rd] takes the launch tag (launch wins over commit-clear).
REQ-024 _clear with rdy_in high: all dep[] <= 0 in that cycle; any same-cycle commit value write still occurs; any same-cycle launch is ignored.
REQ-025 rdy_in low: regs[] and dep[] hold, and read outputs remain combinational on the current state.
REQ-026 Tag width arithmetic is exact; there is no wrap handling, because tags are opaque identifiers.

Reset
REQ-027 rst_in high, asynchronously and regardless of clk_in and rdy_in: all regs[] <= 0 and all dep[] <= 0; read outputs then reflect 0/0.
REQ-028 Reset asserted mid-operation discards all pending tags; the first edge after release behaves as a fresh start.

Structure
REQ-029 A shared package holds XLEN, ROB_ID_W, NO_DEP (= 0), REG_COUNT (= 32) and REG_X0 (= 0), for use by the ROB, decoder and this block.
REQ-030 Single flat module with no sub-module; read-bypass logic is duplicated per port.

Verification
REQ-031 Launch x5 tag 3, next cycle ask x5 -> _dep_rd_1 = 3; commit x5 tag 3 value 0x1234, next cycle -> dep 0, value 0x1234.
REQ-032 x5 renamed to tag 3, then tag 7; commit tag 3 value 0xAA -> regs[5] = 0xAA, dep stays 7; same-cycle read during the tag-7 commit with value 0xBB -> dep 0, value 0xBB (bypass).
REQ-033 Same cycle: launch x8 tag 9 and commit x8 tag 4 value 0x55 (dep[8] = 4) -> regs[8] = 0x55, dep[8] = 9.
REQ-034 Rename x1..x31 with tags 1..31, pulse _clear with commit x2 value 0x77 -> all dep 0, regs[2] = 0x77, any same-cycle launch ignored.
REQ-035 Launch/commit to x0 with value 0xFFFFFFFF -> reads of x0 return dep 0, value 0.
REQ-036 rdy_in low during launch/commit -> no state change; assert rst_in between clock edges -> outputs 0 immediately.
